stepdown_deadtime_ctrl: RTL and testbench
=========================================

STEPDOWN_DEADTIME_CTRL -- requirements
Module: stepdown_deadtime_ctrl

Interface
REQ-001 Parameter DT_W, default 4: width of the dead-time settings.
REQ-002 Parameter TON_W, default 6: width of the minimum-on-time setting.
REQ-003 CELCLK  input  1: block clock; all state updates on its rising edge.
REQ-004 CELRSTN  input  1: reset, asynchronous assert, active-low.
REQ-005 CELV, CELG, SUB  input  1 each: supply, ground and substrate pins; carried for netlisting, no functional effect.
REQ-006 en  input  1: converter enable, synchronous.
REQ-007 pwm_in  input  1: PWM request from the regulation loop, asynchronous.
REQ-008 ocp  input  1: over-current comparator, asynchronous, high = over-current.
REQ-009 dt_hs  input  DT_W: dead time in cycles before high-side turn-on.
REQ-010 dt_ls  input  DT_W: dead time in cycles before low-side turn-on.
REQ-011 ton_min  input  TON_W: minimum high-side on-time in cycles; 0 = no minimum.
REQ-012 hs_drv  output  1: high-side gate request; feeds the downstream gate-drive inverter.
REQ-013 ls_drv  output  1: low-side gate request.
REQ-014 ocp_flag  output  1: cycle-by-cycle current-limit latch.
REQ-015 state_o  output  3: current FSM state encoding, for observation only.

Function
REQ-016 pwm_in and ocp each SHALL pass through a 2-flop synchroniser; "pwm_s" and "ocp_s" below are the synchronised values.
REQ-017 The FSM SHALL have five states: OFF, DT_LH, HS_ON, DT_HL, LS_ON.
REQ-018 hs_drv SHALL be registered and high only in HS_ON; ls_drv SHALL be registered and high only in LS_ON; both SHALL never be high in the same cycle.
REQ-019 OFF -> DT_LH when en=1, pwm_s=1 and ocp_flag=0.
REQ-020 LS_ON -> DT_LH when pwm_s=1 and ocp_flag=0.
REQ-021 Each dead-time state SHALL load a down-counter with max(dt,1) on entry, with dt_hs for DT_LH and dt_ls for DT_HL.
REQ-022 DT_LH SHALL last exactly max(dt_hs,1) cycles, then go to HS_ON.
REQ-023 DT_HL SHALL last exactly max(dt_ls,1) cycles, then go to LS_ON.
REQ-024 Dead-time values SHALL be sampled only at load; later changes SHALL not affect a dead time already in progress.
REQ-025 On HS_ON entry, the block SHALL load ton_min into the min-on counter.
REQ-026 In HS_ON, pwm_s=0 SHALL be ignored while the min-on counter is non-zero; once the counter is zero, pwm_s=0 -> DT_HL.
REQ-027 ocp_s=1 in DT_LH or HS_ON SHALL force DT_HL on the next cycle, overriding min-on, and SHALL set ocp_flag.
REQ-028 ocp_flag SHALL clear in the cycle after pwm_s=0 and ocp_s=0 are observed together.
REQ-029 en=0 in any state SHALL force OFF on the next cycle with both drives low; en has priority over ocp and pwm.
REQ-030 Latency: pwm_in edge to the first drive change SHALL be 3 cycles (2 synchroniser + 1 registered state).

Reset
REQ-031 CELRSTN=0 SHALL asynchronously force OFF, hs_drv=0, ls_drv=0, ocp_flag=0, counters=0, synchronisers=0.
REQ-032 After CELRSTN deasserts, the block SHALL start from OFF, including when reset hits mid-dead-time or in HS_ON.

Structure
REQ-033 A shared package stepdown_loop_pkg SHALL hold the state enum and the DT_W/TON_W defaults.
REQ-034 The 2-flop synchroniser SHALL be a sub-module cel_sync2, instantiated twice.

Verification
REQ-035 Test: en=1, dt_hs=3, dt_ls=2, ton_min=0, pwm_in toggled with 20-cycle period -> ls_drv falls, exactly 3 cycles with both drives low, then hs_drv rises; on the pwm falling edge, exactly 2 low cycles before ls_drv rises.
REQ-036 Test: ton_min=10, pwm_in high for 4 cycles -> hs_drv stays high for exactly 10 cycles.
REQ-037 Test: ocp pulse 5 cycles into HS_ON with ton_min=10 -> hs_drv low 3 cycles after the ocp edge and ocp_flag=1; pwm high again without ocp low first -> no re-entry until pwm and ocp are both seen low.
REQ-038 Test: dt_hs=0 -> 1-cycle dead time; dt_hs changed from 3 to 9 mid-DT_LH -> dead time still 3 cycles.
REQ-039 Test: en=0 during DT_LH -> OFF next cycle, both drives 0; CELRSTN pulsed low in HS_ON -> hs_drv=0 immediately, no clock needed.
REQ-040 Test: assertion over all tests, hs_drv & ls_drv never 1 together.

Source files
------------

// File: rtl/stepdown_loop_pkg.sv
// rtl/stepdown_loop_pkg.sv - state encoding and width defaults for the step-down dead-time controller
package stepdown_loop_pkg;

  localparam int DT_W_DEF  = 4;
  localparam int TON_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DT_LH = 3'd1,
    ST_HS_ON = 3'd2,
    ST_DT_HL = 3'd3,
    ST_LS_ON = 3'd4
  } dt_state_e;

endpackage

// File: rtl/cel_sync2.sv
// rtl/cel_sync2.sv - two-flop synchroniser for asynchronous single-bit inputs
module cel_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/stepdown_deadtime_ctrl.sv
// rtl/stepdown_deadtime_ctrl.sv - buck half-bridge gate sequencer with dead time, min-on and current limit
module stepdown_deadtime_ctrl
  import stepdown_loop_pkg::*;
#(
  parameter int DT_W  = DT_W_DEF,
  parameter int TON_W = TON_W_DEF
) (
  input  logic             CELCLK,
  input  logic             CELRSTN,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             en,
  input  logic             pwm_in,
  input  logic             ocp,
  input  logic [DT_W-1:0]  dt_hs,
  input  logic [DT_W-1:0]  dt_ls,
  input  logic [TON_W-1:0] ton_min,
  output logic             hs_drv,
  output logic             ls_drv,
  output logic             ocp_flag,
  output logic [2:0]       state_o
);

  dt_state_e        state, state_nxt;
  logic [DT_W-1:0]  dt_cnt;
  logic [TON_W-1:0] ton_cnt;
  logic             pwm_s, ocp_s;
  logic             dt_done, ton_done, ocp_trip;
  logic             unused_pins;

  // Supply pins exist only so the netlist carries them.
  assign unused_pins = CELV ^ CELG ^ SUB;

  cel_sync2 u_sync_pwm (.clk(CELCLK), .rst_n(CELRSTN), .d(pwm_in), .q(pwm_s));
  cel_sync2 u_sync_ocp (.clk(CELCLK), .rst_n(CELRSTN), .d(ocp),    .q(ocp_s));

  // Counters hold the cycles remaining including the current one.
  assign dt_done  = (dt_cnt <= DT_W'(1));
  assign ton_done = (ton_cnt <= TON_W'(1));
  assign ocp_trip = en && ocp_s && (state == ST_DT_LH || state == ST_HS_ON);

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF, ST_LS_ON: if (pwm_s && !ocp_flag) state_nxt = ST_DT_LH;
        ST_DT_LH: begin
          if (ocp_s)        state_nxt = ST_DT_HL;
          else if (dt_done) state_nxt = ST_HS_ON;
        end
        ST_HS_ON: begin
          if (ocp_s || (!pwm_s && ton_done)) state_nxt = ST_DT_HL;
        end
        ST_DT_HL: if (dt_done) state_nxt = ST_LS_ON;
        default:  state_nxt = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state    <= ST_OFF;
      hs_drv   <= 1'b0;
      ls_drv   <= 1'b0;
      ocp_flag <= 1'b0;
      dt_cnt   <= '0;
      ton_cnt  <= '0;
    end else begin
      state  <= state_nxt;
      hs_drv <= (state_nxt == ST_HS_ON);
      ls_drv <= (state_nxt == ST_LS_ON);

      // Dead-time settings are captured once on entry and then ignored.
      if (state_nxt == ST_DT_LH && state != ST_DT_LH)
        dt_cnt <= (dt_hs == '0) ? DT_W'(1) : dt_hs;
      else if (state_nxt == ST_DT_HL && state != ST_DT_HL)
        dt_cnt <= (dt_ls == '0) ? DT_W'(1) : dt_ls;
      else if (dt_cnt != '0)
        dt_cnt <= dt_cnt - DT_W'(1);

      if (state_nxt == ST_HS_ON && state != ST_HS_ON)
        ton_cnt <= ton_min;
      else if (ton_cnt != '0)
        ton_cnt <= ton_cnt - TON_W'(1);

      if (ocp_trip)
        ocp_flag <= 1'b1;
      else if (!pwm_s && !ocp_s)
        ocp_flag <= 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_stepdown_deadtime_ctrl.sv
// tb/tb_stepdown_deadtime_ctrl.sv - self-checking bench for stepdown_deadtime_ctrl
module tb_stepdown_deadtime_ctrl;
  import stepdown_loop_pkg::*;

  logic       CELCLK = 1'b0;
  logic       CELRSTN = 1'b0;
  logic       CELV = 1'b1, CELG = 1'b0, SUB = 1'b0;
  logic       en = 1'b0, pwm_in = 1'b0, ocp = 1'b0;
  logic [3:0] dt_hs = 4'd3, dt_ls = 4'd2;
  logic [5:0] ton_min = 6'd0;
  logic       hs_drv, ls_drv, ocp_flag;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  stepdown_deadtime_ctrl #(.DT_W(4), .TON_W(6)) dut (
    .CELCLK(CELCLK), .CELRSTN(CELRSTN), .CELV(CELV), .CELG(CELG), .SUB(SUB),
    .en(en), .pwm_in(pwm_in), .ocp(ocp), .dt_hs(dt_hs), .dt_ls(dt_ls),
    .ton_min(ton_min), .hs_drv(hs_drv), .ls_drv(ls_drv), .ocp_flag(ocp_flag),
    .state_o(state_o)
  );

  always #5 CELCLK = ~CELCLK;

  localparam int P_OFF  = int'(ST_OFF);
  localparam int P_DTLH = int'(ST_DT_LH);
  localparam int P_HS   = int'(ST_HS_ON);
  localparam int P_DTHL = int'(ST_DT_HL);
  localparam int P_LS   = int'(ST_LS_ON);

  // Model: phase plus how long it has lasted, with its length fixed at entry.
  typedef struct {
    int       phase;
    int       age;
    int       len;
    int       ton;
    bit       flag;
    bit [1:0] ps;
    bit [1:0] os;
  } m_t;

  m_t m;

  function automatic m_t model_reset();
    m_t r;
    r.phase = P_OFF; r.age = 0; r.len = 0; r.ton = 0;
    r.flag = 1'b0; r.ps = 2'b00; r.os = 2'b00;
    return r;
  endfunction

  function automatic m_t model_step(m_t c, bit en_i, bit pwm_i, bit ocp_i,
                                    int dth, int dtl, int ton);
    m_t n = c;
    bit ps = c.ps[1];
    bit os = c.os[1];
    int np = c.phase;
    if (!en_i) np = P_OFF;
    else if (c.phase == P_OFF || c.phase == P_LS) begin
      if (ps && !c.flag) np = P_DTLH;
    end else if (c.phase == P_DTLH) begin
      if (os) np = P_DTHL;
      else if (c.age >= c.len) np = P_HS;
    end else if (c.phase == P_HS) begin
      if (os || (!ps && c.age >= c.ton)) np = P_DTHL;
    end else if (c.phase == P_DTHL) begin
      if (c.age >= c.len) np = P_LS;
    end
    if (en_i && os && (c.phase == P_DTLH || c.phase == P_HS)) n.flag = 1'b1;
    else if (!ps && !os) n.flag = 1'b0;
    if (np != c.phase) begin
      n.age = 1;
      if (np == P_DTLH) n.len = (dth < 1) ? 1 : dth;
      if (np == P_DTHL) n.len = (dtl < 1) ? 1 : dtl;
      if (np == P_HS)   n.ton = ton;
    end else begin
      n.age = c.age + 1;
    end
    n.phase = np;
    n.ps = {c.ps[0], pwm_i};
    n.os = {c.os[0], ocp_i};
    return n;
  endfunction

  always @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) m <= model_reset();
    else m <= model_step(m, en, pwm_in, ocp, int'(dt_hs), int'(dt_ls), int'(ton_min));
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CELCLK) begin
    if (chk_en) begin
      check("model_hs_drv", int'(hs_drv), int'(m.phase == P_HS));
      check("model_ls_drv", int'(ls_drv), int'(m.phase == P_LS));
      check("model_ocp_flag", int'(ocp_flag), int'(m.flag));
      check("model_state", int'(state_o), m.phase);
      checks++;
      assert (!(hs_drv && ls_drv)) else begin
        errors++;
        $display("FAIL overlap: hs_drv=%0d ls_drv=%0d required not both 1 at %0t", hs_drv, ls_drv, $time);
      end
    end
  end

  // Pulse-width monitor: both-low run before each rise, and high-side on length.
  int  low_run = 0, gap_hs = -1, gap_ls = -1, hs_run = 0, hs_len = -1;
  logic prev_hs = 1'b0, prev_ls = 1'b0;
  always @(negedge CELCLK) begin
    if (hs_drv && !prev_hs) gap_hs <= low_run;
    if (ls_drv && !prev_ls) gap_ls <= low_run;
    low_run <= (hs_drv || ls_drv) ? 0 : low_run + 1;
    hs_run  <= hs_drv ? (prev_hs ? hs_run + 1 : 1) : 0;
    if (prev_hs && !hs_drv) hs_len <= hs_run;
    prev_hs <= hs_drv;
    prev_ls <= ls_drv;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CELCLK);
    #2;
  endtask

  function automatic logic drv(input int sel);
    return (sel == 0) ? hs_drv : ls_drv;
  endfunction

  task automatic edges_until(input int sel, input logic lvl, output int n);
    n = 0;
    while (drv(sel) != lvl && n < 60) begin
      tick(1);
      n++;
    end
  endtask

  int n;

  initial begin
    tick(3);
    chk_en = 1'b1;
    check("reset_hs_drv", int'(hs_drv), 0);
    check("reset_ls_drv", int'(ls_drv), 0);
    check("reset_ocp_flag", int'(ocp_flag), 0);
    check("reset_state", int'(state_o), P_OFF);
    CELRSTN = 1'b1;
    tick(2);

    // 20-cycle PWM, dt_hs=3, dt_ls=2, no minimum on-time
    en = 1'b1;
    pwm_in = 1'b1; tick(10);
    pwm_in = 1'b0; tick(10);
    pwm_in = 1'b1;
    edges_until(1, 1'b0, n);
    check("pwm_to_ls_fall_latency", n, 3);
    tick(7);
    pwm_in = 1'b0; tick(10);
    check("dead_time_before_hs", gap_hs, 3);
    check("dead_time_before_ls", gap_ls, 2);
    check("hs_on_len_ton0", hs_len, 7);

    // minimum on-time stretches a 4-cycle request to 10 cycles
    ton_min = 6'd10;
    pwm_in = 1'b1; tick(4);
    pwm_in = 1'b0; tick(30);
    check("hs_on_len_ton10", hs_len, 10);

    // over-current 5 cycles into HS_ON, then lockout until pwm and ocp both low
    pwm_in = 1'b1;
    edges_until(0, 1'b1, n);
    check("hs_rise_before_ocp", int'(hs_drv), 1);
    tick(5);
    ocp = 1'b1;
    edges_until(0, 1'b0, n);
    check("ocp_to_hs_fall_latency", n, 3);
    check("ocp_flag_set", int'(ocp_flag), 1);
    ocp = 1'b0;
    tick(20);
    check("ocp_lockout_hs", int'(hs_drv), 0);
    check("ocp_lockout_state", int'(state_o), P_LS);
    check("ocp_flag_held", int'(ocp_flag), 1);
    pwm_in = 1'b0; tick(4);
    check("ocp_flag_cleared", int'(ocp_flag), 0);
    pwm_in = 1'b1; tick(10);
    check("reentry_after_clear", int'(hs_drv), 1);
    pwm_in = 1'b0; tick(25);

    // zero dead time floors at one cycle
    ton_min = 6'd0; dt_hs = 4'd0; dt_ls = 4'd0;
    pwm_in = 1'b1; tick(15);
    pwm_in = 1'b0; tick(15);
    check("dt_hs0_one_cycle", gap_hs, 1);
    check("dt_ls0_one_cycle", gap_ls, 1);

    // dt_hs change mid dead time is not picked up
    dt_hs = 4'd3; dt_ls = 4'd2;
    pwm_in = 1'b1;
    edges_until(1, 1'b0, n);
    dt_hs = 4'd9;
    tick(12);
    pwm_in = 1'b0; tick(15);
    check("dt_hs_frozen_at_load", gap_hs, 3);
    check("dt_ls_restored", gap_ls, 2);
    dt_hs = 4'd3;

    // en=0 in DT_LH forces OFF next cycle
    pwm_in = 1'b1;
    edges_until(1, 1'b0, n);
    en = 1'b0;
    tick(1);
    check("en0_state_off", int'(state_o), P_OFF);
    check("en0_hs_low", int'(hs_drv), 0);
    check("en0_ls_low", int'(ls_drv), 0);
    tick(4);
    check("en0_hs_stays_low", int'(hs_drv), 0);
    en = 1'b1;
    edges_until(0, 1'b1, n);
    check("en1_to_hs_rise", n, 4);
    tick(2);

    // asynchronous reset in HS_ON, no clock edge in between
    CELRSTN = 1'b0;
    #1;
    check("async_rst_hs_low", int'(hs_drv), 0);
    check("async_rst_state_off", int'(state_o), P_OFF);
    #3 CELRSTN = 1'b1;
    tick(1);
    check("post_rst_state_off", int'(state_o), P_OFF);
    tick(8);
    check("post_rst_hs_restart", int'(hs_drv), 1);

    // asynchronous reset in DT_HL
    pwm_in = 1'b0;
    edges_until(0, 1'b0, n);
    CELRSTN = 1'b0;
    #1;
    check("rst_in_dthl_state_off", int'(state_o), P_OFF);
    #3 CELRSTN = 1'b1;
    tick(5);
    check("rst_in_dthl_ls_low", int'(ls_drv), 0);
    check("rst_in_dthl_stays_off", int'(state_o), P_OFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
